// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared FSM encodings, widths and default PCs for pc_fetch
package pc_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_PC  = 32'h0000_0080;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_VALID = 2'b10
  } fetch_state_t;

  // Instructions are word aligned; every PC load goes through this mask.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC mux: reset, redirect, trap, sequential, hold
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_PC  = DEF_TRAP_PC
) (
  input  logic            i_rst,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_br_misalign,
  input  logic            i_advance,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_inc,
  output logic [XLEN-1:0] o_next_pc
);

  // Priority: reset, then redirect (trap if misaligned), then accepted fetch, else hold.
  always_comb begin
    o_next_pc = i_pc;
    if (i_rst) begin
      o_next_pc = word_align(RESET_PC);
    end else if (i_br_taken) begin
      o_next_pc = i_br_misalign ? word_align(TRAP_PC) : word_align(i_br_target);
    end else if (i_advance) begin
      o_next_pc = word_align(i_pc_inc);
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and fetch FSM; optional PC_ALIGN_CHECK_EN traps misaligned redirects
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_PC  = DEF_TRAP_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] pc_inc_i,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            dec_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            misalign_o
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_misalign;
  logic            w_capture;
  logic            w_misalign;

`ifdef PC_ALIGN_CHECK_EN
  assign w_misalign = br_taken & (br_target[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  pc_next_sel #(
    .RESET_PC (RESET_PC),
    .TRAP_PC  (TRAP_PC)
  ) u_next_sel (
    .i_rst         (rst),
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .i_br_misalign (w_misalign),
    .i_advance     (w_capture),
    .i_pc          (r_pc),
    .i_pc_inc      (pc_inc_i),
    .o_next_pc     (w_next_pc)
  );

  // State register; reset parks in IDLE so the first fetch follows one bubble.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and capture strobe; a redirect overrides any same-cycle ack or consume.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (dec_ready) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (br_taken) begin
      w_capture   = 1'b0;
      w_state_nxt = S_FETCH;
    end
  end

  // PC register; all load selection lives in pc_next_sel.
  always_ff @(posedge clk) begin
    r_pc <= w_next_pc;
  end

  // Instruction buffer payload, written only on an accepted fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= imem_rdata;
      r_instr_pc <= r_pc;
    end
  end

  // Misalignment pulse appears the cycle after the trapped redirect.
  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_misalign;
  end

  assign pc_o        = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_VALID);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed and random checks of pc_fetch against a behavioural model
module tb_pc_fetch;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRP_PC  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_o;
  logic [31:0] pc_inc_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        misalign_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pc, one-slot buffer, post-reset bubble flag, trap pulse.
  logic [31:0] m_pc;
  logic        m_full;
  logic        m_bubble;
  logic [31:0] m_buf;
  logic [31:0] m_buf_pc;
  logic        m_mis;

  always #5 clk = ~clk;

  assign pc_inc_i = pc_o + 32'd4;

  pc_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc_o        (pc_o),
    .pc_inc_i    (pc_inc_i),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .dec_ready   (dec_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .misalign_o  (misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic ack, input logic [31:0] rd,
                            input logic rdy, input logic br, input logic [31:0] tgt);
    if (r) begin
      m_pc = RST_PC; m_full = 1'b0; m_bubble = 1'b1;
      m_buf = 32'h0; m_buf_pc = 32'h0; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (br) begin
        m_full = 1'b0; m_bubble = 1'b0;
        if (ALIGN_EN && tgt[1:0] != 2'b00) begin
          m_pc = TRP_PC; m_mis = 1'b1;
        end else begin
          m_pc = {tgt[31:2], 2'b00};
        end
      end else if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (!m_full) begin
        if (ack) begin
          m_buf = rd; m_buf_pc = m_pc; m_pc = m_pc + 32'd4; m_full = 1'b1;
        end
      end else if (rdy) begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("pc_o",        pc_o,               m_pc);
    chk("imem_addr",   imem_addr,          m_pc);
    chk("imem_req",    {31'b0, imem_req},  {31'b0, !m_full && !m_bubble});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_full});
    chk("instr",       instr,              m_buf);
    chk("instr_pc",    instr_pc,           m_buf_pc);
    chk("misalign_o",  {31'b0, misalign_o}, {31'b0, m_mis});
  endtask

  // One clock: drive at negedge, model at posedge, check at the next negedge.
  task automatic cyc(input logic r, input logic ack, input logic [31:0] rd,
                     input logic rdy, input logic br, input logic [31:0] tgt);
    rst = r; imem_ack = ack; imem_rdata = rd; dec_ready = rdy;
    br_taken = br; br_target = tgt;
    @(posedge clk);
    model_edge(r, ack, rd, rdy, br, tgt);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] t;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hDEAD_BEEF, 1, 0, 0);
    // bubble, then four fetches consumed immediately: instr_pc 0,4,8,12
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, $urandom, 0, 0, 0);
      chk("seq_instr_pc", instr_pc, 32'(i * 4));
      cyc(0, 0, 0, 1, 0, 0);
    end
    // reset mid-fetch with ack: ack discarded
    cyc(1, 1, 32'h1234_5678, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // ack withheld five cycles in FETCH
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("stall_pc", pc_o, 32'h0);
    cyc(0, 1, 32'hA5A5_0001, 0, 0, 0);
    // decode stalls four cycles
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("hold_pc", pc_o, 32'h4);
    cyc(0, 0, 0, 1, 0, 0);
    // redirect beats same-cycle ack
    cyc(0, 1, 32'hBAD0_BAD0, 0, 1, 32'h100);
    cyc(0, 1, 32'h0000_0100, 0, 0, 0);
    chk("redir_instr_pc", instr_pc, 32'h100);
    // redirect during VALID with dec_ready
    cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    cyc(0, 1, 32'hFFFF_0000, 0, 0, 0);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 1, 0, 0);
    // misaligned redirect
    cyc(0, 0, 0, 0, 1, 32'h102);
    chk("mis_pc", pc_o, ALIGN_EN ? 32'h80 : 32'h100);
    chk("mis_pulse", {31'b0, misalign_o}, {31'b0, ALIGN_EN});
    cyc(0, 0, 0, 0, 0, 0);
    chk("mis_clear", {31'b0, misalign_o}, 32'h0);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      t = $urandom;
      if ($urandom_range(3) == 0) t[31:24] = 8'hFF;
      cyc(($urandom_range(63) == 0), 1'($urandom), $urandom, 1'($urandom),
          ($urandom_range(9) == 0), t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
